ps2_key_ctrl: RTL

Sequencer that drains the `ps2_keyboard` receive FIFO through its `ready`/`nextdata_n` handshake and decodes the PS/2 set-2 byte stream into make/break key events. It handles the `E0` (extended) and `F0` (break) prefixes. It sits between `ps2_keyboard` and the display/seven-segment logic in `top`, and replaces ad-hoc handshake logic there. Outputs are registered, single-clock-domain event pulses plus a held-key register and a press counter.

---
 rtl/ps2_key_ctrl_if.sv | 29 ++
 rtl/ps2_key_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/ps2_key_ctrl_if.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl_if
// Handshake bundle between the ps2_keyboard receive FIFO and ps2_key_ctrl.
//   ready      : FIFO non-empty flag (FIFO -> controller)
//   data[7:0]  : FIFO head byte, valid while ready=1 (FIFO -> controller)
//   overflow   : FIFO overflow flag (FIFO -> controller)
//   nextdata_n : active-low pop strobe (controller -> FIFO)
// Modports: master = FIFO side, slave = controller side.
// ---------------------------------------------------------------------------
interface ps2_key_ctrl_if;
   logic       ready;
   logic [7:0] data;
   logic       overflow;
   logic       nextdata_n;

   modport master (
      output ready,
      output data,
      output overflow,
      input  nextdata_n
   );

   modport slave (
      input  ready,
      input  data,
      input  overflow,
      output nextdata_n
   );
endinterface

// File: rtl/ps2_key_ctrl.sv
// ---------------------------------------------------------------------------
// ps2_key_ctrl
// Drains the ps2_keyboard receive FIFO (one byte per two cycles) and decodes
// the PS/2 set-2 byte stream into make/break key events, handling the E0
// (extended) and F0 (break) prefixes in either order.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   fifo          : ps2_key_ctrl_if.slave (ready, data, overflow, nextdata_n)
//   key_code[7:0] : scan code of the most recent make event
//   key_ext       : that make event was E0-prefixed
//   key_down      : key in key_code/key_ext is currently held
//   key_press     : one-cycle pulse per accepted make event
//   key_release   : one-cycle pulse per completed break event
//   rel_code[7:0] : scan code of the last break event
//   press_cnt     : count of accepted make events (wraps)
//   ovf_seen      : sticky FIFO overflow indicator
//
// Build option: define PS2_TYPEMATIC_FILTER_EN to suppress key_press and
// press_cnt increments for auto-repeated makes of the held key.
// ---------------------------------------------------------------------------
module ps2_key_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   ps2_key_ctrl_if.slave     fifo,
   output logic [7:0]        key_code,
   output logic              key_ext,
   output logic              key_down,
   output logic              key_press,
   output logic              key_release,
   output logic [7:0]        rel_code,
   output logic [CNT_W-1:0]  press_cnt,
   output logic              ovf_seen
);

   typedef enum logic {S_IDLE, S_DEC} state_t;

   state_t     state_reg;
   logic [7:0] byte_reg;
   logic       ext_pend_reg;
   logic       brk_pend_reg;
   logic       is_repeat;

   // Pop is combinational so the FIFO advances in the same cycle the head
   // byte is latched; reset always wins.
   assign fifo.nextdata_n = !((state_reg == S_IDLE) && fifo.ready && !rst);

`ifdef PS2_TYPEMATIC_FILTER_EN
   // A make that matches the held key exactly is a typematic repeat.
   assign is_repeat = key_down && (byte_reg == key_code) && (ext_pend_reg == key_ext);
`else
   assign is_repeat = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= S_IDLE;
         byte_reg     <= 8'h00;
         ext_pend_reg <= 1'b0;
         brk_pend_reg <= 1'b0;
         key_code     <= 8'h00;
         key_ext      <= 1'b0;
         key_down     <= 1'b0;
         key_press    <= 1'b0;
         key_release  <= 1'b0;
         rel_code     <= 8'h00;
         press_cnt    <= '0;
         ovf_seen     <= 1'b0;
      end else begin
         ovf_seen    <= ovf_seen | fifo.overflow;
         key_press   <= 1'b0;
         key_release <= 1'b0;

         case (state_reg)
            S_IDLE: begin
               if (fifo.ready) begin
                  byte_reg  <= fifo.data;
                  state_reg <= S_DEC;
               end
            end

            S_DEC: begin
               state_reg <= S_IDLE;
               if (byte_reg == 8'hE0) begin
                  ext_pend_reg <= 1'b1;
               end else if (byte_reg == 8'hF0) begin
                  brk_pend_reg <= 1'b1;
               end else if (brk_pend_reg) begin
                  rel_code    <= byte_reg;
                  key_release <= 1'b1;
                  // Only a break of the exact held key (code and extension)
                  // releases it; other breaks just report.
                  if (key_down && (byte_reg == key_code) && (ext_pend_reg == key_ext))
                     key_down <= 1'b0;
                  ext_pend_reg <= 1'b0;
                  brk_pend_reg <= 1'b0;
               end else begin
                  key_code     <= byte_reg;
                  key_ext      <= ext_pend_reg;
                  key_down     <= 1'b1;
                  ext_pend_reg <= 1'b0;
                  if (!is_repeat) begin
                     key_press <= 1'b1;
                     press_cnt <= press_cnt + 1'b1;
                  end
               end
            end

            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule
